laser_host: RTL

- Hardware host for the LASER block; plays the opposite end of its point-stream/DONE protocol.
- Holds a 40-point image loaded by a CPU-side port. On START it streams the points on X/Y, one per cycle, then counts cycles until LASER raises DONE.
- Captures the returned C1/C2 centres and scores coverage: a point is covered when its squared distance to either centre is 16 or less.
- Used for on-chip self-test and for FPGA bring-up of LASER without a simulator.

---
 rtl/laser_host.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/laser_host.sv
// Host-side partner for LASER: streams a stored point image, waits for the
// centre result, then scores how many points fall within radius 4.
module laser_host #(
  parameter int NPTS       = 40,
  parameter int MAX_CYCLES = 50000,
  parameter int CW         = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_EN,
  input  logic [5:0]    LD_ADDR,
  input  logic [3:0]    LD_X,
  input  logic [3:0]    LD_Y,
  input  logic          START,
  output logic [3:0]    X,
  output logic [3:0]    Y,
  input  logic [3:0]    C1X,
  input  logic [3:0]    C1Y,
  input  logic [3:0]    C2X,
  input  logic [3:0]    C2Y,
  input  logic          DONE,
  output logic          BUSY,
  output logic          RES_VALID,
  output logic [5:0]    COVER,
  output logic [CW-1:0] CYCLES,
  output logic [3:0]    R_C1X,
  output logic [3:0]    R_C1Y,
  output logic [3:0]    R_C2X,
  output logic [3:0]    R_C2Y,
  output logic          TIMEOUT,
  output logic          PROTO_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_RUN,
    S_SCORE,
    S_REPORT
  } state_t;

  localparam logic [5:0]    LAST = 6'(NPTS - 1);
  localparam logic [5:0]    NPTS6 = 6'(NPTS);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CLIM = CW'(MAX_CYCLES - 1);

  state_t state;
  state_t state_n;

  logic [3:0] mem_x [NPTS];
  logic [3:0] mem_y [NPTS];
  logic [5:0] idx;
  logic [5:0] idx_nx;

  logic       ld_ok;
  logic       last_idx;
  logic       at_limit;
  logic [8:0] d1;
  logic [8:0] d2;
  logic       hit;

  // Squared distance along one axis; the 5-bit signed difference
  // is folded to its magnitude before squaring.
  function automatic logic [8:0] sq(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic signed [4:0] d;
    logic [4:0]        m;
    logic [8:0]        m9;
    d  = $signed({1'b0, a}) - $signed({1'b0, b});
    m  = (d < 0) ? 5'(-d) : 5'(d);
    m9 = {4'b0, m};
    return m9 * m9;
  endfunction

  assign ld_ok    = (state == S_IDLE) && LD_EN && (LD_ADDR < NPTS6);
  assign last_idx = (idx == LAST);
  assign at_limit = (CYCLES >= CLIM);
  assign idx_nx   = idx + 6'd1;

  assign d1  = sq(mem_x[idx], R_C1X) + sq(mem_y[idx], R_C1Y);
  assign d2  = sq(mem_x[idx], R_C2X) + sq(mem_y[idx], R_C2Y);
  assign hit = (d1 <= 9'd16) || (d2 <= 9'd16);

  assign BUSY      = (state != S_IDLE);
  assign RES_VALID = (state == S_REPORT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          state_n = DONE ? S_REPORT : S_SEND;
        end
      end
      S_SEND: begin
        if (DONE) begin
          state_n = S_REPORT;
        end else if (last_idx) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (DONE || at_limit) begin
          state_n = S_SCORE;
        end
      end
      S_SCORE: begin
        if (last_idx) begin
          state_n = S_REPORT;
        end
      end
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NPTS; i++) begin
        mem_x[i] <= '0;
        mem_y[i] <= '0;
      end
      idx       <= '0;
      X         <= '0;
      Y         <= '0;
      COVER     <= '0;
      CYCLES    <= '0;
      R_C1X     <= '0;
      R_C1Y     <= '0;
      R_C2X     <= '0;
      R_C2Y     <= '0;
      TIMEOUT   <= 1'b0;
      PROTO_ERR <= 1'b0;
    end else begin
      if (ld_ok) begin
        mem_x[LD_ADDR] <= LD_X;
        mem_y[LD_ADDR] <= LD_Y;
      end
      unique case (state)
        S_IDLE: begin
          if (START) begin
            COVER     <= '0;
            CYCLES    <= '0;
            TIMEOUT   <= 1'b0;
            PROTO_ERR <= DONE;
            idx       <= '0;
            // Point 0 is on the bus right after the accepting edge.
            if (!DONE) begin
              X <= mem_x[0];
              Y <= mem_y[0];
            end
          end
        end
        S_SEND: begin
          if (DONE || last_idx) begin
            X         <= '0;
            Y         <= '0;
            PROTO_ERR <= DONE;
          end else begin
            idx <= idx_nx;
            X   <= mem_x[idx_nx];
            Y   <= mem_y[idx_nx];
          end
        end
        S_RUN: begin
          if (DONE || at_limit) begin
            R_C1X <= C1X;
            R_C1Y <= C1Y;
            R_C2X <= C2X;
            R_C2Y <= C2Y;
            idx   <= '0;
            if (!DONE) begin
              CYCLES  <= CMAX;
              TIMEOUT <= 1'b1;
            end
          end else begin
            CYCLES <= CYCLES + 1'b1;
          end
        end
        S_SCORE: begin
          COVER <= COVER + {5'b0, hit};
          if (!last_idx) begin
            idx <= idx_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
